// File: rtl/gate3_stim_gen.sv
// gate3_stim_gen: drives a 3-input AND cell from registers, samples its
// looped-back output on Q_IN, and counts applied vectors, output toggles
// and mismatches against the ideal AND of the applied inputs.
module gate3_stim_gen #(
  parameter int          CNT_W     = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [1:0]       MODE,
  input  logic [CNT_W-1:0] NVEC,
  input  logic             Q_IN,
  output logic             IN1,
  output logic             IN2,
  output logic             IN3,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] VEC_CNT,
  output logic [CNT_W-1:0] TOGGLE_CNT,
  output logic [CNT_W-1:0] ERR_CNT
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  // An all-zero seed would lock the LFSR, so it is swapped for the default
  localparam logic [15:0]      SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] nvec_q, nvec_d;
  logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0] tog_cnt_q, tog_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             prev_q, prev_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [2:0]       vec_q, vec_d;

  logic [15:0]      lfsr_next;
  logic [CNT_W-1:0] vec_cnt_inc;
  logic             exp_bit;

  // Fibonacci step for x^16+x^14+x^13+x^11+1, shifting toward bit 0
  assign lfsr_next = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

  // Saturating increment shared by all counters
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // Next-state, vector generation and counter updates
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    nvec_d      = nvec_q;
    vec_cnt_d   = vec_cnt_q;
    tog_cnt_d   = tog_cnt_q;
    err_cnt_d   = err_cnt_q;
    prev_d      = prev_q;
    lfsr_d      = lfsr_q;
    vec_d       = vec_q;
    vec_cnt_inc = sat_inc(vec_cnt_q);
    exp_bit     = &vec_q;

    case (state_q)
      S_IDLE: begin
        vec_d = 3'b000;
        if (START) begin
          mode_d    = MODE;
          nvec_d    = NVEC;
          vec_cnt_d = '0;
          tog_cnt_d = '0;
          err_cnt_d = '0;
          prev_d    = 1'b0;
          lfsr_d    = SEED_EFF;
          if (NVEC != '0) begin
            state_d = S_RUN;
            case (MODE)
              2'd1:    vec_d = SEED_EFF[2:0];
              2'd2:    vec_d = 3'b001;
              default: vec_d = 3'b000;
            endcase
          end else begin
            state_d = S_FIN;
          end
        end
      end

      S_RUN: begin
        if (Q_IN != exp_bit) begin
          err_cnt_d = sat_inc(err_cnt_q);
        end
        if (Q_IN != prev_q) begin
          tog_cnt_d = sat_inc(tog_cnt_q);
        end
        prev_d    = Q_IN;
        vec_cnt_d = vec_cnt_inc;
        if (vec_cnt_q == nvec_q - CNT_ONE) begin
          state_d = S_FIN;
          vec_d   = 3'b000;
        end else begin
          case (mode_q)
            2'd1: begin
              lfsr_d = lfsr_next;
              vec_d  = lfsr_next[2:0];
            end
            2'd2:    vec_d = {vec_q[1:0], vec_q[2]};
            default: vec_d = vec_cnt_inc[2:0];
          endcase
        end
      end

      S_FIN: begin
        vec_d   = 3'b000;
        state_d = S_IDLE;
      end

      default: begin
        vec_d   = 3'b000;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      mode_q    <= 2'd0;
      nvec_q    <= '0;
      vec_cnt_q <= '0;
      tog_cnt_q <= '0;
      err_cnt_q <= '0;
      prev_q    <= 1'b0;
      lfsr_q    <= LFSR_SEED;
      vec_q     <= 3'b000;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      nvec_q    <= nvec_d;
      vec_cnt_q <= vec_cnt_d;
      tog_cnt_q <= tog_cnt_d;
      err_cnt_q <= err_cnt_d;
      prev_q    <= prev_d;
      lfsr_q    <= lfsr_d;
      vec_q     <= vec_d;
    end
  end

  assign IN1        = vec_q[0];
  assign IN2        = vec_q[1];
  assign IN3        = vec_q[2];
  assign BUSY       = (state_q == S_RUN);
  assign DONE       = (state_q == S_FIN);
  assign VEC_CNT    = vec_cnt_q;
  assign TOGGLE_CNT = tog_cnt_q;
  assign ERR_CNT    = err_cnt_q;

endmodule

// File: tb/tb_gate3_stim_gen.sv
// Bench for gate3_stim_gen: a behavioural cell and run model predicts every
// output each cycle, and directed runs pin the model with literal values.
module tb_gate3_stim_gen;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic [15:0] nvec;
  logic        q_in;
  logic        in1, in2, in3;
  logic        busy, done;
  logic [15:0] vec_cnt, toggle_cnt, err_cnt;

  int tests    = 0;
  int failures = 0;
  bit run_checks = 0;
  bit fault_sa1  = 0;

  gate3_stim_gen #(.CNT_W(16), .LFSR_SEED(16'hACE1)) dut (
    .CLK(clk), .RST(rst), .START(start), .MODE(mode), .NVEC(nvec), .Q_IN(q_in),
    .IN1(in1), .IN2(in2), .IN3(in3), .BUSY(busy), .DONE(done),
    .VEC_CNT(vec_cnt), .TOGGLE_CNT(toggle_cnt), .ERR_CNT(err_cnt)
  );

  // The cell under test: ideal AND, or stuck-at-1 when the fault is enabled
  assign q_in = fault_sa1 ? 1'b1 : (in1 & in2 & in3);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector k of a run, derived directly from the pattern definitions
  function automatic logic [2:0] vec_of(input int md, input int k);
    logic [15:0] s;
    logic [2:0]  v;
    int          r;
    case (md)
      1: begin
        s = 16'hACE1;
        for (int i = 0; i < k; i++) s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
        v = s[2:0];
      end
      2: begin
        r = k % 3;
        v = (r == 0) ? 3'b001 : ((r == 1) ? 3'b010 : 3'b100);
      end
      default: begin
        r = k % 8;
        v = r[2:0];
      end
    endcase
    return v;
  endfunction

  // Model state: run progress and the counts the checker must report
  int m_mode = 0;
  int m_n    = 0;
  int m_k    = 0;
  int m_tog  = 0;
  int m_err  = 0;
  bit m_prev = 0;
  bit m_busy = 0;
  bit m_done = 0;

  // Model advance: one vector checked per cycle while a run is active
  always @(posedge clk or posedge rst) begin
    logic [2:0] v;
    bit q;
    if (rst) begin
      m_mode = 0; m_n = 0; m_k = 0; m_tog = 0; m_err = 0;
      m_prev = 0; m_busy = 0; m_done = 0;
    end else if (m_busy) begin
      v = vec_of(m_mode, m_k);
      q = fault_sa1 ? 1'b1 : (v == 3'b111);
      if (q != (v == 3'b111) && m_err < 65535) m_err++;
      if (q != m_prev && m_tog < 65535) m_tog++;
      m_prev = q;
      m_k++;
      if (m_k == m_n) begin
        m_busy = 0;
        m_done = 1;
      end
    end else if (m_done) begin
      m_done = 0;
    end else if (start) begin
      m_mode = (mode == 2'd3) ? 0 : int'(mode);
      m_n = int'(nvec);
      m_k = 0; m_tog = 0; m_err = 0; m_prev = 0;
      if (m_n != 0) m_busy = 1;
      else          m_done = 1;
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the rising edge
  always @(negedge clk) begin
    logic [2:0] ev;
    if (run_checks) begin
      ev = m_busy ? vec_of(m_mode, m_k) : 3'b000;
      checkOutput("cyc_in",     int'({in3, in2, in1}), int'(ev));
      checkOutput("cyc_busy",   int'(busy),            int'(m_busy));
      checkOutput("cyc_done",   int'(done),            int'(m_done));
      checkOutput("cyc_vec",    int'(vec_cnt),         m_k);
      checkOutput("cyc_toggle", int'(toggle_cnt),      m_tog);
      checkOutput("cyc_err",    int'(err_cnt),         m_err);
    end
  end

  // Issue one START pulse; returns at the falling edge inside cycle t
  task automatic applyStimulus(input logic [1:0] md, input logic [15:0] n);
    @(negedge clk);
    mode  = md;
    nvec  = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait for DONE with a cycle budget, reporting latency and busy cycles
  task automatic waitDone(output int cycles, output int busy_cycles);
    cycles = 0;
    busy_cycles = 0;
    while (!done && cycles < 200) begin
      if (busy) busy_cycles++;
      @(negedge clk);
      cycles++;
    end
    if (!done) checkOutput("done_timeout", 0, 1);
  endtask

  int cyc, bcyc, extra_done;
  logic [2:0] walk_lit [0:5];
  logic [2:0] lfsr_lit [0:3];

  initial begin
    walk_lit[0] = 3'b001; walk_lit[1] = 3'b010; walk_lit[2] = 3'b100;
    walk_lit[3] = 3'b001; walk_lit[4] = 3'b010; walk_lit[5] = 3'b100;
    lfsr_lit[0] = 3'b001; lfsr_lit[1] = 3'b000; lfsr_lit[2] = 3'b000; lfsr_lit[3] = 3'b100;

    start = 1'b0; mode = 2'd0; nvec = 16'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_in",   int'({in3, in2, in1}), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_cnts", int'(vec_cnt) + int'(toggle_cnt) + int'(err_cnt), 0);
    #1 rst = 1'b0;
    run_checks = 1;

    // Exhaustive, ideal cell
    applyStimulus(2'd0, 16'd8);
    waitDone(cyc, bcyc);
    checkOutput("t1_done_cycle", cyc, 8);
    checkOutput("t1_busy_cycles", bcyc, 8);
    checkOutput("t1_vec", int'(vec_cnt), 8);
    checkOutput("t1_err", int'(err_cnt), 0);
    checkOutput("t1_toggle", int'(toggle_cnt), 1);

    // Walking one, ideal cell
    applyStimulus(2'd2, 16'd6);
    for (int i = 0; i < 6; i++) begin
      checkOutput("t2_walk_vec", int'({in3, in2, in1}), int'(walk_lit[i]));
      @(negedge clk);
    end
    checkOutput("t2_done", int'(done), 1);
    checkOutput("t2_toggle", int'(toggle_cnt), 0);
    checkOutput("t2_err", int'(err_cnt), 0);

    // Exhaustive with stuck-at-1 cell
    fault_sa1 = 1'b1;
    applyStimulus(2'd0, 16'd8);
    waitDone(cyc, bcyc);
    checkOutput("t3_err", int'(err_cnt), 7);
    checkOutput("t3_toggle", int'(toggle_cnt), 1);
    @(negedge clk);
    fault_sa1 = 1'b0;

    // Zero-length run
    applyStimulus(2'd0, 16'd0);
    waitDone(cyc, bcyc);
    checkOutput("t4_done_cycle", cyc, 0);
    checkOutput("t4_busy_cycles", bcyc, 0);
    checkOutput("t4_cnts", int'(vec_cnt) + int'(toggle_cnt) + int'(err_cnt), 0);

    // Single-vector run and mode 3 behaving as exhaustive
    applyStimulus(2'd0, 16'd1);
    waitDone(cyc, bcyc);
    checkOutput("nvec1_done_cycle", cyc, 1);
    checkOutput("nvec1_vec", int'(vec_cnt), 1);
    applyStimulus(2'd3, 16'd10);
    waitDone(cyc, bcyc);
    checkOutput("mode3_vec", int'(vec_cnt), 10);
    checkOutput("mode3_toggle", int'(toggle_cnt), 2);

    // LFSR run aborted by reset, then repeated from the top
    applyStimulus(2'd1, 16'd20);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("t5_rst_in", int'({in3, in2, in1}), 0);
    checkOutput("t5_rst_busy", int'(busy), 0);
    checkOutput("t5_rst_vec", int'(vec_cnt), 0);
    @(negedge clk);
    #1 rst = 1'b0;
    applyStimulus(2'd1, 16'd20);
    for (int i = 0; i < 4; i++) begin
      checkOutput("t5_lfsr_vec", int'({in3, in2, in1}), int'(lfsr_lit[i]));
      @(negedge clk);
    end
    waitDone(cyc, bcyc);
    checkOutput("t5_vec", int'(vec_cnt), 20);

    // START during RUN with a different NVEC is ignored
    applyStimulus(2'd0, 16'd5);
    repeat (2) @(negedge clk);
    nvec  = 16'd12;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(cyc, bcyc);
    checkOutput("t6_done_cycle", cyc, 2);
    checkOutput("t6_vec", int'(vec_cnt), 5);
    extra_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) extra_done++;
    end
    checkOutput("t6_extra_done", extra_done, 0);
    checkOutput("t6_idle_busy", int'(busy), 0);

    run_checks = 0;
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
